// File: rtl/pipe_stage_shell_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_shell_if
//
// Purpose:
//   Stream interface that connects the pipeline shell to its producer (fetch)
//   and its consumer (writeback). Both sides use valid/ready semantics:
//   a transfer happens on a clock edge where valid and ready are both high.
//
// Signals:
//   in_valid   fetch offers a payload to stage 0
//   in_ready   stage 0 can accept a payload this cycle
//   in_data    payload loaded into stage 0
//   out_valid  oldest stage holds a finished payload
//   out_ready  writeback accepts the payload this cycle
//   out_data   payload of the oldest stage
//
// Modports:
//   slave   the pipeline shell's view
//   master  the surrounding core's view (fetch + writeback)
// ---------------------------------------------------------------------------
interface pipe_stage_shell_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface : pipe_stage_shell_if

// File: rtl/pipe_stage_shell.sv
// ---------------------------------------------------------------------------
// pipe_stage_shell
//
// Purpose:
//   Parametrised in-order pipeline skeleton. Holds one payload register and
//   one valid bit per stage and moves payloads forward with an
//   allowin / ready_go handshake. The per-stage datapath lives outside: it
//   reads stage_data slice i and presents the payload for stage i+1 on
//   stage_next_data slice i. Stage 0 is the youngest, stage NUM_STAGES-1
//   the oldest.
//
//   A flush request from stage i kills every younger stage and the payload
//   entering from fetch; the flushing stage itself moves on normally.
//
//   Two performance counters are kept: retired payloads (out handshakes)
//   and fetch stall cycles (in_valid while stage 0 cannot accept).
//
// Ports:
//   clk              clock
//   reset            synchronous, active-high reset
//   io               stream interface (slave): in_valid/in_ready/in_data,
//                    out_valid/out_ready/out_data
//   stage_ready_go   bit i: stage i has finished its work this cycle
//   stage_next_data  slice i: payload stage i hands to stage i+1
//                    (top slice unused)
//   stage_flush      bit i: kill all stages younger than i and the input
//   stage_valid      valid bit per stage
//   stage_data       registered payload per stage, slice i = stage i
//   stage_allowin    allowin per stage (combinational)
//   retire_cnt       number of out handshakes, wraps
//   stall_cnt        number of in_valid & !in_ready cycles, wraps
// ---------------------------------------------------------------------------
module pipe_stage_shell #(
  parameter int NUM_STAGES = 5,
  parameter int DATA_W     = 64,
  parameter int CNT_W      = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  pipe_stage_shell_if.slave            io,
  input  logic [NUM_STAGES-1:0]        stage_ready_go,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_next_data,
  input  logic [NUM_STAGES-1:0]        stage_flush,
  output logic [NUM_STAGES-1:0]        stage_valid,
  output logic [NUM_STAGES*DATA_W-1:0] stage_data,
  output logic [NUM_STAGES-1:0]        stage_allowin,
  output logic [CNT_W-1:0]             retire_cnt,
  output logic [CNT_W-1:0]             stall_cnt
);

  // -------------------------------------------------------------------------
  // Stage state
  // -------------------------------------------------------------------------
  logic [NUM_STAGES-1:0] valid_q;
  logic [DATA_W-1:0]     data_q [NUM_STAGES];

  // allowin[NUM_STAGES] is the sink's ready, so the chain has one extra bit.
  logic [NUM_STAGES:0]   allowin;
  logic [NUM_STAGES-1:0] go;
  logic [NUM_STAGES-1:0] kill;
  logic                  kill_in;

  logic [CNT_W-1:0]      retire_q;
  logic [CNT_W-1:0]      stall_q;

  logic                  out_fire;
  logic                  in_stall;

  // -------------------------------------------------------------------------
  // Allowin chain, oldest to youngest.
  // A running scalar carries allowin[i+1] down the loop so the vector never
  // reads itself, which keeps the chain a plain combinational ripple.
  // -------------------------------------------------------------------------
  always_comb begin
    logic allow_older;
    // NOTE: every variable assigned in a combinational block gets a value on
    // every path first; otherwise the tool infers a latch to hold the old one.
    allowin     = '0;
    allow_older = io.out_ready;
    allowin[NUM_STAGES] = io.out_ready;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      allow_older = !valid_q[i] | (stage_ready_go[i] & allow_older);
      allowin[i]  = allow_older;
    end
  end

  // A stage hands its payload on when it is valid, done, and the next stage
  // (or the sink, for the oldest stage) has room.
  always_comb begin
    go = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      go[i] = valid_q[i] & stage_ready_go[i] & allowin[i+1];
    end
  end

  // -------------------------------------------------------------------------
  // Kill vector: kill[j] is set when any older stage (k > j) flushes.
  // Multiple flush bits therefore collapse to the oldest one automatically.
  // -------------------------------------------------------------------------
  always_comb begin
    logic flush_older;
    kill        = '0;
    flush_older = 1'b0;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      kill[j]     = flush_older;
      flush_older = flush_older | stage_flush[j];
    end
  end

  // Any flush, including stage 0's own, drops the payload entering from fetch.
  assign kill_in = |stage_flush;

  // -------------------------------------------------------------------------
  // Stage 0: loaded from the fetch stream.
  // in_ready is deliberately not gated by flush: the fetch side sees a normal
  // handshake and the payload is simply not marked valid.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every stage
    // samples the values from before the edge, giving true register behaviour.
    if (reset) begin
      valid_q[0] <= 1'b0;
      // NOTE: payload registers are reset too; consumers ignore them while
      // invalid, but a defined value keeps the observable outputs repeatable.
      data_q[0]  <= '0;
    end else if (kill[0]) begin
      valid_q[0] <= 1'b0;
    end else if (allowin[0]) begin
      valid_q[0] <= io.in_valid & !kill_in;
      if (io.in_valid) begin
        data_q[0] <= io.in_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stages 1..NUM_STAGES-1: loaded from the previous stage's datapath output.
  // A killed stage keeps its payload bits; only the valid bit clears.
  // -------------------------------------------------------------------------
  for (genvar i = 1; i < NUM_STAGES; i++) begin : g_stage
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
      end else if (kill[i]) begin
        valid_q[i] <= 1'b0;
      end else if (allowin[i]) begin
        // The previous stage's own flush kills what it would hand over only
        // when an older flush applies; kill[i-1] covers both cases.
        valid_q[i] <= go[i-1] & !kill[i-1];
        if (go[i-1]) begin
          data_q[i] <= stage_next_data[(i-1)*DATA_W +: DATA_W];
        end
      end
    end
  end

  // The oldest stage has no successor, so its next-data slice is not needed.
  logic unused_next_tail;
  assign unused_next_tail = ^stage_next_data[(NUM_STAGES-1)*DATA_W +: DATA_W];

  // -------------------------------------------------------------------------
  // Performance counters. Both wrap naturally at 2^CNT_W.
  // -------------------------------------------------------------------------
  assign out_fire = io.out_valid & io.out_ready;
  assign in_stall = io.in_valid & !io.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_q <= '0;
      stall_q  <= '0;
    end else begin
      if (out_fire) begin
        retire_q <= retire_q + CNT_W'(1);
      end
      if (in_stall) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_out
    assign stage_data[i*DATA_W +: DATA_W] = data_q[i];
  end

  assign stage_valid   = valid_q;
  assign stage_allowin = allowin[NUM_STAGES-1:0];

  assign io.in_ready   = allowin[0];
  assign io.out_valid  = valid_q[NUM_STAGES-1] & stage_ready_go[NUM_STAGES-1];
  assign io.out_data   = data_q[NUM_STAGES-1];

  assign retire_cnt    = retire_q;
  assign stall_cnt     = stall_q;

endmodule : pipe_stage_shell

// File: tb/tb_pipe_stage_shell.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_shell
//
// Self-checking bench for pipe_stage_shell built with NUM_STAGES=5, DATA_W=8,
// CNT_W=4. The external datapath adds 1 per stage, so a payload d accepted
// at the input leaves the pipe as d+4. Expected outputs are pushed into a
// queue by the stimulus process; a monitor pops and compares on every out
// handshake. Directed checks cover stage state after stalls and flushes.
// ---------------------------------------------------------------------------
module tb_pipe_stage_shell;

  localparam int NS = 5;
  localparam int DW = 8;
  localparam int CW = 4;

  logic             clk;
  logic             reset;
  logic [NS-1:0]    stage_ready_go;
  logic [NS*DW-1:0] stage_next_data;
  logic [NS-1:0]    stage_flush;
  logic [NS-1:0]    stage_valid;
  logic [NS*DW-1:0] stage_data;
  logic [NS-1:0]    stage_allowin;
  logic [CW-1:0]    retire_cnt;
  logic [CW-1:0]    stall_cnt;

  pipe_stage_shell_if #(.DATA_W(DW)) bus ();

  pipe_stage_shell #(
    .NUM_STAGES (NS),
    .DATA_W     (DW),
    .CNT_W      (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .io              (bus),
    .stage_ready_go  (stage_ready_go),
    .stage_next_data (stage_next_data),
    .stage_flush     (stage_flush),
    .stage_valid     (stage_valid),
    .stage_data      (stage_data),
    .stage_allowin   (stage_allowin),
    .retire_cnt      (retire_cnt),
    .stall_cnt       (stall_cnt)
  );

  // External datapath: each stage increments the payload by one.
  for (genvar i = 0; i < NS; i++) begin : g_dp
    assign stage_next_data[i*DW +: DW] = stage_data[i*DW +: DW] + 8'd1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mon_exp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] sd(input int i);
    return stage_data[i*DW +: DW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one payload for one cycle; it must be accepted.
  task automatic feed(input logic [DW-1:0] d, input bit keep);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    #1;
    check("feed_in_ready", bus.in_ready, 1);
    if (keep) exp_q.push_back(d + 8'd4);
    step();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (stage_valid != '0 && n < 20) begin
      step();
      n++;
    end
    check("drain_done", stage_valid, 0);
  endtask

  // Monitor: compare every retiring payload against the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL out_unexpected: got 0x%0h, required no output (t=%0t)", bus.out_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_data", bus.out_data, mon_exp);
      end
    end
  end

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] next;

    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    stage_ready_go = '1;
    stage_flush    = '0;
    step();
    step();
    reset = 1'b0;
    #1;

    // ---- Reset state ----
    check("rst_valid",     stage_valid, 0);
    check("rst_data",      stage_data, 0);
    check("rst_in_ready",  bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_retire",    retire_cnt, 0);
    check("rst_stall",     stall_cnt, 0);

    // ---- Streaming: 0x10,0x20,0x30 -> 0x14,0x24,0x34 ----
    feed(8'h10, 1);
    feed(8'h20, 1);
    feed(8'h30, 1);
    bus.in_valid = 1'b0;
    step();
    step();
    check("stream_valid",     stage_valid, 5'b11100);
    check("stream_out_valid", bus.out_valid, 1);
    check("stream_s2",        sd(2), 8'h32);
    wait_drain();
    check("stream_retire", retire_cnt, 3);
    check("stream_stall",  stall_cnt, 0);

    // ---- Back-pressure: fill, then hold stage 2 for three cycles ----
    feed(8'h40, 1);
    feed(8'h50, 1);
    feed(8'h60, 1);
    feed(8'h70, 1);
    feed(8'h80, 1);
    stage_ready_go[2] = 1'b0;
    bus.in_valid      = 1'b1;
    bus.in_data       = 8'h90;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready", bus.in_ready, 0);
      step();
      check("bp_valid", stage_valid, (k == 0) ? 5'b10111 : 5'b00111);
      check("bp_frozen", {sd(0), sd(1), sd(2)}, {8'h80, 8'h71, 8'h62});
    end
    stage_ready_go = '1;
    exp_q.push_back(8'h94);
    #1;
    check("bp_release_ready", bus.in_ready, 1);
    step();
    wait_drain();
    check("bp_stall",  stall_cnt, 3);
    check("bp_retire", retire_cnt, 9);

    // ---- Branch flush from stage 2 ----
    feed(8'hA0, 1);
    feed(8'hB0, 0);
    feed(8'hC0, 0);
    stage_flush  = 5'b00100;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hD0;
    #1;
    check("flush_in_ready", bus.in_ready, 1);
    step();
    stage_flush  = '0;
    bus.in_valid = 1'b0;
    check("flush_valid", stage_valid, 5'b01000);
    check("flush_s3",    sd(3), 8'hA3);
    wait_drain();
    check("flush_retire", retire_cnt, 10);

    // ---- Simultaneous flush from stages 1 and 3 ----
    feed(8'h11, 1);
    feed(8'h21, 0);
    feed(8'h31, 0);
    feed(8'h41, 0);
    bus.in_valid = 1'b0;
    stage_flush  = 5'b01010;
    step();
    stage_flush = '0;
    check("mflush_valid", stage_valid, 5'b10000);
    check("mflush_s4",    sd(4), 8'h15);
    wait_drain();
    check("mflush_retire", retire_cnt, 11);

    // ---- Flush from stage 0 drops only the input ----
    feed(8'h55, 1);
    stage_flush  = 5'b00001;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h66;
    step();
    stage_flush  = '0;
    bus.in_valid = 1'b0;
    check("f0_valid", stage_valid, 5'b00010);
    check("f0_s1",    sd(1), 8'h56);
    wait_drain();
    check("f0_retire", retire_cnt, 12);

    // ---- Retire counter wrap at 2^CNT_W ----
    for (int i = 0; i < 3; i++) begin
      feed(8'h01 + 8'(i), 1);
      wait_drain();
    end
    check("wrap_pre", retire_cnt, 4'hF);
    feed(8'h07, 1);
    wait_drain();
    check("wrap_post", retire_cnt, 0);

    // ---- Sink stall: fill to five valid, then drain in order ----
    bus.out_ready = 1'b0;
    next = 8'hE0;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = next;
      #1;
      if (bus.in_ready) begin
        exp_q.push_back(next + 8'd4);
        next = next + 8'd1;
      end
      step();
    end
    bus.in_valid = 1'b0;
    #1;
    check("sink_valid",    stage_valid, 5'b11111);
    check("sink_in_ready", bus.in_ready, 0);
    check("sink_accepted", next, 8'hE5);
    bus.out_ready = 1'b1;
    wait_drain();
    check("sink_stall",  stall_cnt, 8);
    check("sink_retire", retire_cnt, 5);

    // ---- Mid-operation reset with a full pipe ----
    bus.out_ready = 1'b0;
    feed(8'h21, 0);
    feed(8'h22, 0);
    feed(8'h23, 0);
    feed(8'h24, 0);
    feed(8'h25, 0);
    bus.in_valid = 1'b0;
    check("mrst_full", stage_valid, 5'b11111);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("mrst_valid",     stage_valid, 0);
    check("mrst_retire",    retire_cnt, 0);
    check("mrst_stall",     stall_cnt, 0);
    check("mrst_in_ready",  bus.in_ready, 1);
    check("mrst_out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    step();

    check("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pipe_stage_shell

// File: doc/pipe_stage_shell.md
Name: pipe_stage_shell

Overview:
- Parametrised in-order pipeline skeleton: N stages, each one payload register plus a valid bit.
- Stages are linked by an allowin/ready_go handshake, with per-stage flush of younger stages.
- Replaces the hard-coded always-write stage registers and separate stall/flush wires of the 5-stage core.
- Stage datapath logic stays outside: it reads each stage's payload and supplies the next-stage payload.
- Also provides retire and stall performance counters.

Parameters:
- NUM_STAGES, 5, number of stage registers (>=2); stage 0 youngest (IF/ID), stage NUM_STAGES-1 oldest (MEM/WB).
- DATA_W, 64, payload width per stage.
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  fetch offers a payload.
- in_ready  out  1  stage 0 can accept (= allowin[0]).
- in_data  in  DATA_W  payload loaded into stage 0.
- stage_ready_go  in  NUM_STAGES  bit i: stage i's work is done this cycle.
- stage_next_data  in  NUM_STAGES*DATA_W  slice i: payload stage i hands to stage i+1; slice NUM_STAGES-1 unused.
- stage_flush  in  NUM_STAGES  bit i: kill all stages younger than i, plus the input.
- stage_valid  out  NUM_STAGES  valid bit per stage.
- stage_data  out  NUM_STAGES*DATA_W  registered payload per stage, slice i = stage i.
- stage_allowin  out  NUM_STAGES  allowin per stage.
- out_valid  out  1  = valid[N-1] & ready_go[N-1].
- out_data  out  DATA_W  = stage_data slice N-1.
- out_ready  in  1  writeback accepts (acts as allowin[N]).
- retire_cnt  out  CNT_W  count of out handshakes.
- stall_cnt  out  CNT_W  count of cycles with in_valid & !in_ready.

Behaviour:
- Reset: all valid 0, all payloads 0, retire_cnt and stall_cnt 0. Outputs follow: in_ready=1, out_valid=0.
- Allowin (combinational): allowin[i] = !valid[i] | (ready_go[i] & allowin[i+1]), with allowin[N] = out_ready. Chain is combinational, no bubble needed to advance.
- go[i] = valid[i] & ready_go[i] & allowin[i+1].
- kill[j] = OR of stage_flush[k] for k>j. kill_in = |stage_flush.
- Stage i>0 update each cycle, highest priority first:
  - reset -> valid 0.
  - kill[i] -> valid 0, payload held.
  - allowin[i] -> valid <= go[i-1] & !kill[i-1], and payload <= stage_next_data slice i-1 when go[i-1].
  - else hold.
- Stage 0 update:
  - kill[0] -> valid 0.
  - allowin[0] -> valid <= in_valid & !kill_in, and payload <= in_data when in_valid.
- Flush details:
  - The flushing stage itself is not killed and advances normally.
  - in_ready is not gated by flush: a handshake during flush completes and the payload is dropped.
  - Several flush bits at once behave as the oldest asserted bit.
  - stage_flush[0] kills only the input.
- Latency: a payload accepted at cycle t is visible at stage i at cycle t+1+i when nothing stalls. Throughput is 1 per cycle.
- Stall: ready_go[i]=0 holds stage i. Stall back-pressure reaches younger stages in the same cycle; older stages drain and become invalid (bubble).
- out handshake: out_valid & out_ready. On a handshake, retire_cnt += 1.
- stall_cnt += 1 on each in_valid & !in_ready cycle.
- Both counters wrap modulo 2^CNT_W; no saturation.
- Payload and counters change only on the posedge; all outputs are registered except in_ready, stage_allowin and out_valid.
- Invalid stages: payload is don't-care to consumers. Counters never count invalid entries.

Test Plan:
- Streaming: N=5, DATA_W=8, stage_next_data[i]=stage_data[i]+1, all ready_go=1, out_ready=1, in_data 0x10,0x20,0x30 on cycles 1-3. Expect out_data 0x14,0x24,0x34 on cycles 6-8, retire_cnt=3, stall_cnt=0.
- Back-pressure: hold ready_go[2]=0 for 3 cycles while streaming. Expect stages 0-2 frozen and in_ready=0 for 3 cycles, stall_cnt=3, stage 3 bubble, no payload lost or duplicated.
- Branch flush: pulse stage_flush[2] with stages 0-2 valid. Next cycle stage_valid[1:0]=00, stage 3 holds stage 2's payload, stage 2 invalid, and the input accepted that cycle is dropped.
- Simultaneous flush: stage_flush[1] and [3] together. Expect the same result as [3] alone, stages 0-2 invalid.
- Sink stall and wrap: out_ready=0 for 10 cycles, then release. Expect the pipe to fill to 5 valid, in_ready=0, then drain in order. Preload retire_cnt to 2^CNT_W-1 via CNT_W=4 build: one retire wraps it to 0.
- Mid-operation reset: assert reset with all stages valid. Next cycle all stage_valid=0, counters 0, in_ready=1, out_valid=0.
